alu_op_sequencer: RTL and testbench



---
 rtl/alu_seq_pkg.sv | 19 +
 rtl/btn_debounce.sv | 59 +++++
 rtl/alu_op_sequencer.sv | 136 +++++++++++++
 tb/tb_alu_op_sequencer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU operation sequencer: FSM states and ALU opcodes.
package alu_seq_pkg;

  // Encodings are visible on state_o and drive the board LEDs directly.
  typedef enum logic [1:0] {
    S_LOAD_A  = 2'b00,
    S_LOAD_B  = 2'b01,
    S_LOAD_OP = 2'b10,
    S_EXEC    = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } alu_op_t;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability-counter debouncer,
// and a registered single-cycle pulse on each debounced rising edge.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_TC = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q;
  logic          btn_s_q;
  logic          btn_db_q, btn_db_d;
  logic          btn_db_prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;

  // The debounced level only moves after DEBOUNCE_CYCLES consecutive samples
  // that disagree with it; any sample that agrees restarts the count.
  always_comb begin
    btn_db_d = btn_db_q;
    cnt_d    = cnt_q;
    if (btn_s_q == btn_db_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_TC) begin
      btn_db_d = ~btn_db_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
    press_d = btn_db_q & ~btn_db_prev_q;
  end

  // Synchroniser, debounce state and edge-detect registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q       <= 1'b0;
      btn_s_q       <= 1'b0;
      btn_db_q      <= 1'b0;
      btn_db_prev_q <= 1'b0;
      cnt_q         <= '0;
      press_q       <= 1'b0;
    end else begin
      sync1_q       <= btn;
      btn_s_q       <= sync1_q;
      btn_db_q      <= btn_db_d;
      btn_db_prev_q <= btn_db_q;
      cnt_q         <= cnt_d;
      press_q       <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/alu_op_sequencer.sv
// Button-driven operand/opcode loader feeding a 2-bit ALU. Each debounced
// press captures the switches into the next slot; after the opcode is taken
// the result is computed once and presented with a one-cycle valid strobe.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned W               = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         btn,
  input  logic [W-1:0] sw,
  output logic [W-1:0] a_q,
  output logic [W-1:0] b_q,
  output logic [1:0]   op_q,
  output logic [W-1:0] res,
  output logic         carry,
  output logic         zero,
  output logic         res_valid,
  output logic [1:0]   state_o
);

  logic press;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn),
    .press(press)
  );

  state_t       state_q, state_d;
  logic [W-1:0] a_d, b_d;
  logic [1:0]   op_d;
  logic [W-1:0] res_q, res_d;
  logic         carry_q, carry_d;
  logic         zero_q, zero_d;
  logic         res_valid_q, res_valid_d;

  logic [W:0]   sum_w;
  logic [W-1:0] alu_res;
  logic         alu_carry;

  // ALU on the captured operands; carry is the ADD carry-out or SUB borrow.
  always_comb begin
    sum_w     = {1'b0, a_q} + {1'b0, b_q};
    alu_res   = '0;
    alu_carry = 1'b0;
    case (alu_op_t'(op_q))
      OP_ADD: begin
        alu_res   = sum_w[W-1:0];
        alu_carry = sum_w[W];
      end
      OP_SUB: begin
        alu_res   = a_q - b_q;
        alu_carry = (a_q < b_q);
      end
      OP_AND:  alu_res = a_q & b_q;
      OP_OR:   alu_res = a_q | b_q;
      default: alu_res = '0;
    endcase
  end

  // Next-state and capture logic; results hold until the next execution.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    res_d       = res_q;
    carry_d     = carry_q;
    zero_d      = zero_q;
    res_valid_d = 1'b0;
    case (state_q)
      S_LOAD_A: begin
        if (press) begin
          a_d     = sw;
          state_d = S_LOAD_B;
        end
      end
      S_LOAD_B: begin
        if (press) begin
          b_d     = sw;
          state_d = S_LOAD_OP;
        end
      end
      S_LOAD_OP: begin
        if (press) begin
          op_d    = sw[1:0];
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        res_d       = alu_res;
        carry_d     = alu_carry;
        zero_d      = (alu_res == '0);
        res_valid_d = 1'b1;
        state_d     = S_LOAD_A;
      end
      default: state_d = S_LOAD_A;
    endcase
  end

  // State, operand and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_LOAD_A;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      res_q       <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      res_q       <= res_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign res       = res_q;
  assign carry     = carry_q;
  assign zero      = zero_q;
  assign res_valid = res_valid_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;

  localparam int W  = 2;
  localparam int DB = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         btn = 1'b0;
  logic [W-1:0] sw  = '0;
  logic [W-1:0] a_q, b_q, res;
  logic [1:0]   op_q, state_o;
  logic         carry, zero, res_valid;

  alu_op_sequencer #(.DEBOUNCE_CYCLES(DB), .W(W)) dut (
    .clk(clk), .rst(rst), .btn(btn), .sw(sw),
    .a_q(a_q), .b_q(b_q), .op_q(op_q), .res(res),
    .carry(carry), .zero(zero), .res_valid(res_valid), .state_o(state_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int execs = 0;
  int valids = 0;

  typedef struct {
    int a; int b; int op; int res; int c; int z;
  } exp_t;
  exp_t q[$];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic modulo 4.
  function automatic exp_t model(input int a, input int b, input int op);
    exp_t e;
    int s;
    e.a = a; e.b = b; e.op = op; e.c = 0;
    case (op)
      0: begin s = a + b; e.res = s % 4; e.c = (s > 3) ? 1 : 0; end
      1: begin e.res = (a - b + 4) % 4; e.c = (a < b) ? 1 : 0; end
      2: e.res = a & b;
      default: e.res = a | b;
    endcase
    e.z = (e.res == 0) ? 1 : 0;
    return e;
  endfunction

  // Hold btn high then low long enough for one clean debounced press; sw
  // is stable while high and scrambled while low.
  task automatic press_val(input int v);
    @(negedge clk);
    sw  = W'(v);
    btn = 1'b1;
    repeat (10) @(negedge clk);
    btn = 1'b0;
    repeat (10) begin
      @(negedge clk);
      sw = W'($urandom_range(0, 3));
    end
  endtask

  task automatic run_op(input int a, input int b, input int op);
    press_val(a);
    press_val(b);
    q.push_back(model(a, b, op));
    execs++;
    press_val(op);
    chk("state_after_op", int'(state_o), 0);
  endtask

  // Monitor: pops an expectation on every res_valid strobe.
  logic       prev_valid = 1'b0;
  logic [1:0] prev_state = 2'b00;
  always @(negedge clk) begin
    if (!rst && res_valid) begin
      exp_t e;
      valids++;
      chk("valid_single_cycle", int'(prev_valid), 0);
      chk("valid_after_exec", int'(prev_state), 3);
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL valid_unexpected actual=res_valid_high required=no_pending_op t=%0t", $time);
      end else begin
        e = q.pop_front();
        chk("a_q", int'(a_q), e.a);
        chk("b_q", int'(b_q), e.b);
        chk("op_q", int'(op_q), e.op);
        chk("res", int'(res), e.res);
        chk("carry", int'(carry), e.c);
        chk("zero", int'(zero), e.z);
      end
    end
    prev_valid = res_valid;
    prev_state = state_o;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    int r0, a0;

    // Reset.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_a_q", int'(a_q), 0);
    chk("rst_b_q", int'(b_q), 0);
    chk("rst_op_q", int'(op_q), 0);
    chk("rst_res", int'(res), 0);
    chk("rst_carry", int'(carry), 0);
    chk("rst_zero", int'(zero), 0);
    chk("rst_valid", int'(res_valid), 0);
    chk("rst_state", int'(state_o), 0);

    // Short glitch: 3 cycles high must not produce a press.
    btn = 1'b1;
    repeat (3) @(negedge clk);
    btn = 1'b0;
    repeat (15) @(negedge clk);
    chk("glitch_state", int'(state_o), 0);
    chk("glitch_a_q", int'(a_q), 0);

    // Clean press: latency and exactly one transition.
    sw  = 2'd3;
    btn = 1'b1;
    lat = 0;
    while (state_o == 2'b00 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    total++;
    if (lat < 6 || lat > 9) begin
      bad++;
      $display("FAIL press_latency actual=%0d required=6..9", lat);
    end
    repeat (10 - lat) @(negedge clk);
    btn = 1'b0;
    repeat (12) @(negedge clk);
    chk("single_press_state", int'(state_o), 1);
    chk("single_press_a_q", int'(a_q), 3);

    // Asynchronous reset mid S_LOAD_B.
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_state", int'(state_o), 0);
    chk("async_rst_a_q", int'(a_q), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_rst_state", int'(state_o), 0);

    // Directed operations.
    run_op(3, 2, 0);
    run_op(1, 2, 1);
    run_op(2, 2, 1);
    run_op(2, 3, 2);
    run_op(1, 2, 3);

    // Hold: switches move, no press, nothing changes.
    r0 = int'(res);
    a0 = int'(a_q);
    repeat (20) begin
      @(negedge clk);
      sw = W'($urandom_range(0, 3));
      chk("hold_res", int'(res), r0);
      chk("hold_a_q", int'(a_q), a0);
      chk("hold_valid", int'(res_valid), 0);
      chk("hold_state", int'(state_o), 0);
    end

    // Random operations.
    repeat (12) begin
      run_op(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    repeat (5) @(negedge clk);
    chk("valid_count", valids, execs);
    chk("queue_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
